guess_digit_buffer: RTL and testbench

Digit-entry buffer that consumes the `hex`/`pulse` stream produced by the switch-edge input stage and assembles a fixed-length guess for the game core. It collects octal digits (0–7) left-shifted into a display register and supports delete and enter commands. On enter, it offers the completed guess to the game logic over a valid/ready handshake. It sits between the switch input stage and the comparison/scoring block; its `digits` bus also drives the seven-segment display.

---
 rtl/guess_digit_buffer.sv | 143 ++++++++++++++
 tb/tb_guess_digit_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/guess_digit_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : guess_digit_buffer
//  Description : Collects octal digits from the switch-edge input stage into
//                a NUM_DIGITS-long entry, supports delete/enter, and hands a
//                completed guess to the game core over valid/ready.
//                Optional macro GUESS_UNIQUE_DIGITS_EN rejects a digit that
//                is already present in the entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module guess_digit_buffer #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              hex,
  input  logic                    pulse,
  input  logic                    del,
  input  logic                    enter,
  input  logic                    guess_ready,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [3:0]              digit_cnt,
  output logic                    guess_valid,
  output logic [4*NUM_DIGITS-1:0] guess_data,
  output logic                    busy,
  output logic                    err
);

  localparam int         c_width    = 4 * NUM_DIGITS;
  localparam logic [3:0] c_full_cnt = 4'(NUM_DIGITS);

  typedef enum logic [0:0] {
    ST_EDIT = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t               r_state;
  logic [c_width-1:0]   r_digits;
  logic [3:0]           r_cnt;
  logic [c_width-1:0]   r_gdata;
  logic                 r_err;

  state_t               w_state_nxt;
  logic [c_width-1:0]   w_digits_nxt;
  logic [3:0]           w_cnt_nxt;
  logic [c_width-1:0]   w_gdata_nxt;
  logic                 w_err_nxt;
  logic [c_width-1:0]   w_shift_in;
  logic                 w_dup;

`ifdef GUESS_UNIQUE_DIGITS_EN
  // Flag a digit that matches any occupied nibble of the current entry.
  always_comb begin
    w_dup = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((4'(i) < r_cnt) && (r_digits[4*i +: 4] == hex)) begin
        w_dup = 1'b1;
      end
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  // Entry shifted left one digit with the new digit in the low nibble.
  always_comb begin
    w_shift_in      = r_digits << 4;
    w_shift_in[3:0] = hex;
  end

  // Next-state and command decode; one command per cycle, enter > del > pulse.
  always_comb begin
    w_state_nxt  = r_state;
    w_digits_nxt = r_digits;
    w_cnt_nxt    = r_cnt;
    w_gdata_nxt  = r_gdata;
    w_err_nxt    = 1'b0;
    case (r_state)
      ST_EDIT: begin
        if (enter) begin
          if (r_cnt == c_full_cnt) begin
            w_gdata_nxt = r_digits;
            w_state_nxt = ST_SEND;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else if (del) begin
          if (r_cnt != 4'd0) begin
            w_digits_nxt = r_digits >> 4;
            w_cnt_nxt    = r_cnt - 4'd1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else if (pulse) begin
          // Non-octal digit, full entry or duplicate are all rejected.
          if (hex[3] || (r_cnt == c_full_cnt) || w_dup) begin
            w_err_nxt = 1'b1;
          end else begin
            w_digits_nxt = w_shift_in;
            w_cnt_nxt    = r_cnt + 4'd1;
          end
        end
      end
      ST_SEND: begin
        // Strobes are ignored here; only the handshake moves us on.
        if (guess_ready) begin
          w_state_nxt  = ST_EDIT;
          w_digits_nxt = '0;
          w_cnt_nxt    = 4'd0;
        end
      end
      default: begin
        w_state_nxt = ST_EDIT;
      end
    endcase
  end

  // State and output registers; reset wins over any strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_EDIT;
      r_digits <= '0;
      r_cnt    <= 4'd0;
      r_gdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_digits <= w_digits_nxt;
      r_cnt    <= w_cnt_nxt;
      r_gdata  <= w_gdata_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign digits      = r_digits;
  assign digit_cnt   = r_cnt;
  assign guess_data  = r_gdata;
  assign guess_valid = (r_state == ST_SEND);
  assign busy        = (r_state == ST_SEND);
  assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_guess_digit_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_guess_digit_buffer
//  Description : Self-checking bench for guess_digit_buffer: directed vector
//                table followed by random stimulus against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_guess_digit_buffer;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [3:0]    hex = 4'd0;
  logic          pulse = 1'b0;
  logic          del = 1'b0;
  logic          enter = 1'b0;
  logic          guess_ready = 1'b0;
  logic [4*N-1:0] digits;
  logic [3:0]    digit_cnt;
  logic          guess_valid;
  logic [4*N-1:0] guess_data;
  logic          busy;
  logic          err;

  int total = 0;
  int bad   = 0;

  guess_digit_buffer #(.NUM_DIGITS(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .hex         (hex),
    .pulse       (pulse),
    .del         (del),
    .enter       (enter),
    .guess_ready (guess_ready),
    .digits      (digits),
    .digit_cnt   (digit_cnt),
    .guess_valid (guess_valid),
    .guess_data  (guess_data),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        pulse;
    logic [3:0]  hex;
    logic        del;
    logic        enter;
    logic        ready;
    logic [15:0] e_digits;
    logic [3:0]  e_cnt;
    logic        e_valid;
    logic        e_busy;
    logic        e_err;
    logic [15:0] e_gdata;
  } vec_t;

  vec_t tbl[36];

  function automatic vec_t mk(logic r, logic p, logic [3:0] h, logic d, logic e, logic rd,
                              logic [15:0] ed, logic [3:0] ec, logic ev, logic eb,
                              logic ee, logic [15:0] eg);
    vec_t v;
    v.rst = r; v.pulse = p; v.hex = h; v.del = d; v.enter = e; v.ready = rd;
    v.e_digits = ed; v.e_cnt = ec; v.e_valid = ev; v.e_busy = eb; v.e_err = ee;
    v.e_gdata = eg;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs and let the edge happen; sample 1 ns later.
  task automatic cycle(input logic r, input logic p, input logic [3:0] h,
                       input logic d, input logic e, input logic rd);
    rst = r; pulse = p; hex = h; del = d; enter = e; guess_ready = rd;
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  int          q[$];
  bit          m_send;
  logic [15:0] m_gdata;
  bit          m_err;

  function automatic logic [15:0] pack_q();
    logic [15:0] val = 16'd0;
    foreach (q[i]) val = val * 16 + 16'(q[i]);
    return val;
  endfunction

  function automatic bit in_q(int h);
    foreach (q[i]) if (q[i] == h) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input logic r, input logic p, input logic [3:0] h,
                            input logic d, input logic e, input logic rd);
    m_err = 1'b0;
    if (r) begin
      q.delete(); m_send = 1'b0; m_gdata = 16'd0;
    end else if (m_send) begin
      if (rd) begin
        m_send = 1'b0; q.delete();
      end
    end else if (e) begin
      if (q.size() == N) begin
        m_gdata = pack_q(); m_send = 1'b1;
      end else m_err = 1'b1;
    end else if (d) begin
      if (q.size() > 0) void'(q.pop_back());
      else m_err = 1'b1;
    end else if (p) begin
      bit dup_reject = 1'b0;
`ifdef GUESS_UNIQUE_DIGITS_EN
      dup_reject = in_q(int'(h));
`endif
      if (h >= 8 || q.size() == N || dup_reject) m_err = 1'b1;
      else q.push_back(int'(h));
    end
  endtask

  initial begin
    logic [15:0] d27, d28;
    logic [3:0]  c27, c28;
    logic        e27;
`ifdef GUESS_UNIQUE_DIGITS_EN
    d27 = 16'h0004; c27 = 4'd1; e27 = 1'b1;
    d28 = 16'h0040; c28 = 4'd2;
`else
    d27 = 16'h0044; c27 = 4'd2; e27 = 1'b0;
    d28 = 16'h0440; c28 = 4'd3;
`endif
    //            rst p  hex  d  e  rdy  digits   cnt v  b  err gdata
    tbl[0]  = mk(1, 0, 4'd0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000);
    tbl[1]  = mk(0, 1, 4'd3, 0, 0, 0, 16'h0003, 1, 0, 0, 0, 16'h0000);
    tbl[2]  = mk(0, 1, 4'd1, 0, 0, 0, 16'h0031, 2, 0, 0, 0, 16'h0000);
    tbl[3]  = mk(0, 1, 4'd7, 0, 0, 0, 16'h0317, 3, 0, 0, 0, 16'h0000);
    tbl[4]  = mk(0, 1, 4'd5, 0, 0, 0, 16'h3175, 4, 0, 0, 0, 16'h0000);
    tbl[5]  = mk(0, 1, 4'd2, 0, 0, 0, 16'h3175, 4, 0, 0, 1, 16'h0000);
    tbl[6]  = mk(0, 0, 4'd0, 0, 1, 1, 16'h3175, 4, 1, 1, 0, 16'h3175);
    tbl[7]  = mk(0, 0, 4'd0, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 16'h3175);
    tbl[8]  = mk(0, 0, 4'd0, 1, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h3175);
    tbl[9]  = mk(0, 1, 4'd9, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h3175);
    tbl[10] = mk(0, 1, 4'd3, 0, 0, 0, 16'h0003, 1, 0, 0, 0, 16'h3175);
    tbl[11] = mk(0, 1, 4'd1, 0, 0, 0, 16'h0031, 2, 0, 0, 0, 16'h3175);
    tbl[12] = mk(0, 1, 4'd7, 0, 0, 0, 16'h0317, 3, 0, 0, 0, 16'h3175);
    tbl[13] = mk(0, 1, 4'd5, 0, 0, 0, 16'h3175, 4, 0, 0, 0, 16'h3175);
    tbl[14] = mk(0, 0, 4'd0, 1, 0, 0, 16'h0317, 3, 0, 0, 0, 16'h3175);
    tbl[15] = mk(0, 0, 4'd0, 1, 0, 0, 16'h0031, 2, 0, 0, 0, 16'h3175);
    tbl[16] = mk(0, 0, 4'd0, 0, 1, 1, 16'h0031, 2, 0, 0, 1, 16'h3175);
    tbl[17] = mk(0, 1, 4'd7, 0, 0, 0, 16'h0317, 3, 0, 0, 0, 16'h3175);
    tbl[18] = mk(0, 1, 4'd5, 0, 0, 0, 16'h3175, 4, 0, 0, 0, 16'h3175);
    tbl[19] = mk(0, 1, 4'd2, 0, 1, 0, 16'h3175, 4, 1, 1, 0, 16'h3175);
    tbl[20] = mk(0, 1, 4'd6, 0, 0, 0, 16'h3175, 4, 1, 1, 0, 16'h3175);
    tbl[21] = mk(0, 0, 4'd0, 1, 0, 0, 16'h3175, 4, 1, 1, 0, 16'h3175);
    tbl[22] = mk(0, 1, 4'd9, 0, 0, 0, 16'h3175, 4, 1, 1, 0, 16'h3175);
    tbl[23] = mk(0, 0, 4'd0, 1, 1, 0, 16'h3175, 4, 1, 1, 0, 16'h3175);
    tbl[24] = mk(0, 1, 4'd1, 0, 0, 0, 16'h3175, 4, 1, 1, 0, 16'h3175);
    tbl[25] = mk(0, 0, 4'd0, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 16'h3175);
    tbl[26] = mk(0, 1, 4'd4, 0, 0, 0, 16'h0004, 1, 0, 0, 0, 16'h3175);
    tbl[27] = mk(0, 1, 4'd4, 0, 0, 0, d27,      c27, 0, 0, e27, 16'h3175);
    tbl[28] = mk(0, 1, 4'd0, 0, 0, 0, d28,      c28, 0, 0, 0, 16'h3175);
    tbl[29] = mk(1, 1, 4'd2, 1, 1, 1, 16'h0000, 0, 0, 0, 0, 16'h0000);
    tbl[30] = mk(0, 1, 4'd1, 0, 0, 0, 16'h0001, 1, 0, 0, 0, 16'h0000);
    tbl[31] = mk(0, 1, 4'd2, 0, 0, 0, 16'h0012, 2, 0, 0, 0, 16'h0000);
    tbl[32] = mk(0, 1, 4'd3, 0, 0, 0, 16'h0123, 3, 0, 0, 0, 16'h0000);
    tbl[33] = mk(0, 1, 4'd4, 0, 0, 0, 16'h1234, 4, 0, 0, 0, 16'h0000);
    tbl[34] = mk(0, 0, 4'd0, 0, 1, 0, 16'h1234, 4, 1, 1, 0, 16'h1234);
    tbl[35] = mk(1, 0, 4'd0, 0, 1, 1, 16'h0000, 0, 0, 0, 0, 16'h0000);

    // Directed table
    for (int i = 0; i < 36; i++) begin
      cycle(tbl[i].rst, tbl[i].pulse, tbl[i].hex, tbl[i].del, tbl[i].enter, tbl[i].ready);
      chk($sformatf("row%0d digits", i), 32'(digits),      32'(tbl[i].e_digits));
      chk($sformatf("row%0d cnt", i),    32'(digit_cnt),   32'(tbl[i].e_cnt));
      chk($sformatf("row%0d valid", i),  32'(guess_valid), 32'(tbl[i].e_valid));
      chk($sformatf("row%0d busy", i),   32'(busy),        32'(tbl[i].e_busy));
      chk($sformatf("row%0d err", i),    32'(err),         32'(tbl[i].e_err));
      chk($sformatf("row%0d gdata", i),  32'(guess_data),  32'(tbl[i].e_gdata));
    end

    // Random stimulus against the queue model, starting from reset
    q.delete(); m_send = 1'b0; m_gdata = 16'd0; m_err = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      logic r, p, d, e, rd;
      logic [3:0] h;
      r  = (n == 0) || ($urandom_range(0, 199) == 0);
      p  = ($urandom_range(0, 99) < 45);
      h  = 4'($urandom_range(0, 9));
      d  = ($urandom_range(0, 99) < 15);
      e  = ($urandom_range(0, 99) < 15);
      rd = ($urandom_range(0, 99) < 30);
      cycle(r, p, h, d, e, rd);
      model_step(r, p, h, d, e, rd);
      chk($sformatf("rnd%0d digits", n), 32'(digits),      32'(pack_q()));
      chk($sformatf("rnd%0d cnt", n),    32'(digit_cnt),   32'(q.size()));
      chk($sformatf("rnd%0d valid", n),  32'(guess_valid), 32'(m_send));
      chk($sformatf("rnd%0d busy", n),   32'(busy),        32'(m_send));
      chk($sformatf("rnd%0d err", n),    32'(err),         32'(m_err));
      chk($sformatf("rnd%0d gdata", n),  32'(guess_data),  32'(m_gdata));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
